// File: rtl/spu_pkg.sv
// ---------------------------------------------------------------------------
// spu_pkg
// Shared types and constants for the even-pipe writeback / forwarding logic.
//   REG_W       : register width in bits
//   REG_ADDR_W  : register address width (128 registers)
//   wb_entry_t  : one in-flight result (data, destination, write enable)
// Bit ordering follows the pipeline's big-endian convention: bit 0 is MSB.
// ---------------------------------------------------------------------------
package spu_pkg;

    localparam int REG_W      = 128;
    localparam int REG_ADDR_W = 7;

    typedef struct packed {
        logic [0:REG_W-1]      data;
        logic [0:REG_ADDR_W-1] addr;
        logic                  we;
    } wb_entry_t;

    // Value a delay-line slot holds after reset: commits nothing, forwards nothing.
    localparam wb_entry_t WB_ENTRY_IDLE = '0;

    // True when an in-flight entry produces the register being read.
    function automatic logic entry_hits(input wb_entry_t e,
                                        input logic [0:REG_ADDR_W-1] a);
        return e.we && (e.addr == a);
    endfunction

endpackage

// File: rtl/even_fwd_wb_fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
// Picks the value for one source operand from the in-flight result list.
//   i_addr    : operand source register address
//   i_rf_data : raw RegTable read data for that address
//   i_cand    : candidates, index 0 = highest priority (youngest)
//   o_data    : forwarded operand value (combinational)
// The first candidate that is valid and matches the address wins; with no
// match the RegTable value passes through unchanged.
// ---------------------------------------------------------------------------
module fwd_select
    import spu_pkg::*;
#(
    parameter int NUM_CAND = 6
) (
    input  logic [0:REG_ADDR_W-1]      i_addr,
    input  logic [0:REG_W-1]           i_rf_data,
    input  wb_entry_t [0:NUM_CAND-1]   i_cand,
    output logic [0:REG_W-1]           o_data
);

    // Scan from oldest to youngest so a later (younger) hit overrides an
    // earlier one; this gives "first match in priority order" without a
    // separate found flag.
    always_comb begin
        o_data = i_rf_data;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (entry_hits(i_cand[i], i_addr)) begin
                o_data = i_cand[i].data;
            end
        end
    end

endmodule

// File: rtl/even_fwd_wb.sv
// ---------------------------------------------------------------------------
// even_fwd_wb
// Writeback and forwarding stage after the single-precision execution unit.
// Two result lanes per cycle (A = FP7 integer, older; B = FP6, younger) run
// through a WB_DEPTH-stage delay line and then commit to the RegTable via two
// write ports. Every in-flight result is forwarded to the ra/rb/rc operands
// of the instruction currently in RF/FWD.
//
// Ports
//   clk, reset                    : clock, synchronous active-high reset
//   rt_wb/rt_addr_wb/reg_write_wb : lane B result, destination, valid
//   rt_int/rt_addr_int/reg_write_int : lane A result, destination, valid
//   ra/rb/rc_addr, ra/rb/rc_rf    : operand addresses and raw RegTable data
//   ra, rb, rc                    : forwarded operands (combinational)
//   rf_we/addr/data_a, _b         : RegTable write ports (registered)
//
// DATA_W and ADDR_W must match REG_W / REG_ADDR_W in spu_pkg; the delay-line
// entries are built from that package type.
// ---------------------------------------------------------------------------
module even_fwd_wb
    import spu_pkg::*;
#(
    parameter int WB_DEPTH = 2,          // 1..7
    parameter int DATA_W   = REG_W,
    parameter int ADDR_W   = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    // lane B (FP6, younger)
    input  logic [0:DATA_W-1] rt_wb,
    input  logic [0:ADDR_W-1] rt_addr_wb,
    input  logic              reg_write_wb,
    // lane A (FP7 integer, older)
    input  logic [0:DATA_W-1] rt_int,
    input  logic [0:ADDR_W-1] rt_addr_int,
    input  logic              reg_write_int,
    // operand sources of the instruction in RF/FWD
    input  logic [0:ADDR_W-1] ra_addr,
    input  logic [0:ADDR_W-1] rb_addr,
    input  logic [0:ADDR_W-1] rc_addr,
    input  logic [0:DATA_W-1] ra_rf,
    input  logic [0:DATA_W-1] rb_rf,
    input  logic [0:DATA_W-1] rc_rf,
    output logic [0:DATA_W-1] ra,
    output logic [0:DATA_W-1] rb,
    output logic [0:DATA_W-1] rc,
    // RegTable write ports
    output logic              rf_we_a,
    output logic              rf_we_b,
    output logic [0:ADDR_W-1] rf_addr_a,
    output logic [0:ADDR_W-1] rf_addr_b,
    output logic [0:DATA_W-1] rf_data_a,
    output logic [0:DATA_W-1] rf_data_b
);

    // Input lanes plus both lanes of every delay-line stage.
    localparam int NUM_CAND = 2 * WB_DEPTH + 2;
    localparam int NUM_OPS  = 3;

    // -----------------------------------------------------------------------
    // Capture
    // -----------------------------------------------------------------------
    logic      w_collide;
    wb_entry_t w_in_a;
    wb_entry_t w_in_b;

    // Both lanes targeting the same register in the same cycle: the younger
    // lane B must be the architectural winner, so lane A is squashed before
    // it ever enters the delay line and never reaches the write port.
    assign w_collide = reg_write_int && reg_write_wb && (rt_addr_int == rt_addr_wb);

    always_comb begin
        w_in_a      = WB_ENTRY_IDLE;
        w_in_a.data = rt_int;
        w_in_a.addr = rt_addr_int;
        w_in_a.we   = reg_write_int && !w_collide;

        w_in_b      = WB_ENTRY_IDLE;
        w_in_b.data = rt_wb;
        w_in_b.addr = rt_addr_wb;
        w_in_b.we   = reg_write_wb;
    end

    // -----------------------------------------------------------------------
    // Delay line
    // -----------------------------------------------------------------------
    wb_entry_t r_stage_a [WB_DEPTH];
    wb_entry_t r_stage_b [WB_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            // Every in-flight result is dropped; nothing reaches the RegTable.
            for (int i = 0; i < WB_DEPTH; i++) begin
                r_stage_a[i] <= WB_ENTRY_IDLE;
                r_stage_b[i] <= WB_ENTRY_IDLE;
            end
        end else begin
            r_stage_a[0] <= w_in_a;
            r_stage_b[0] <= w_in_b;
            for (int i = 1; i < WB_DEPTH; i++) begin
                r_stage_a[i] <= r_stage_a[i-1];
                r_stage_b[i] <= r_stage_b[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Commit: write ports come straight from the last stage's registers.
    // -----------------------------------------------------------------------
    assign rf_we_a   = r_stage_a[WB_DEPTH-1].we;
    assign rf_addr_a = r_stage_a[WB_DEPTH-1].addr;
    assign rf_data_a = r_stage_a[WB_DEPTH-1].data;

    assign rf_we_b   = r_stage_b[WB_DEPTH-1].we;
    assign rf_addr_b = r_stage_b[WB_DEPTH-1].addr;
    assign rf_data_b = r_stage_b[WB_DEPTH-1].data;

    // -----------------------------------------------------------------------
    // Forwarding candidates, youngest first. Within a stage lane B precedes
    // lane A. The last stage stays in the list because the RegTable returns
    // the old value when read and written in the same cycle.
    // -----------------------------------------------------------------------
    wb_entry_t [0:NUM_CAND-1] w_cand;

    always_comb begin
        w_cand    = '0;
        w_cand[0] = w_in_b;
        w_cand[1] = w_in_a;
        for (int i = 0; i < WB_DEPTH; i++) begin
            w_cand[2 + 2*i] = r_stage_b[i];
            w_cand[3 + 2*i] = r_stage_a[i];
        end
    end

    // -----------------------------------------------------------------------
    // One selector per operand; they share the candidate list.
    // -----------------------------------------------------------------------
    logic [0:ADDR_W-1] w_op_addr [NUM_OPS];
    logic [0:DATA_W-1] w_op_rf   [NUM_OPS];
    logic [0:DATA_W-1] w_op_out  [NUM_OPS];

    assign w_op_addr[0] = ra_addr;
    assign w_op_addr[1] = rb_addr;
    assign w_op_addr[2] = rc_addr;
    assign w_op_rf[0]   = ra_rf;
    assign w_op_rf[1]   = rb_rf;
    assign w_op_rf[2]   = rc_rf;

    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_fwd
            fwd_select #(
                .NUM_CAND (NUM_CAND)
            ) u_fwd_select (
                .i_addr    (w_op_addr[gi]),
                .i_rf_data (w_op_rf[gi]),
                .i_cand    (w_cand),
                .o_data    (w_op_out[gi])
            );
        end
    endgenerate

    assign ra = w_op_out[0];
    assign rb = w_op_out[1];
    assign rc = w_op_out[2];

endmodule
